// File: rtl/arb_requester.sv
// arb_requester: requester-side agent for a 4-way round-robin arbiter.
// Buffers producer words in a FIFO, requests the bus while a complete packet
// (or a full FIFO) is queued, drives one word per granted cycle onto the
// shared bus, and flags starvation and grants that arrive while idle.
module arb_requester #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              request,
  input  logic              grant,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              starve,
  input  logic              starve_clr,
  output logic              spurious_grant
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  // FIFO storage: {last, data}; pointers wrap naturally since DEPTH is a power of 2
  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic [CW-1:0]   pkt_cnt, pkt_cnt_nxt;
  logic [TW-1:0]   wait_cnt;
  logic            full, empty;
  logic            push, pop_en;
  logic [DATA_W:0] rd_word;
  logic            pop_last;
  logic            req_nxt;
  logic            req_q;
  logic            req_fell;
  state_t          state, state_nxt;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign wr_ready = !full;
  assign push     = wr_valid && wr_ready;

  // A full FIFO requests even without a complete packet so overlength
  // packets cut through instead of deadlocking.
  assign request  = (pkt_cnt != '0) || full;
  assign pop_en   = grant && request && !empty;
  assign rd_word  = mem[rd_ptr];
  assign pop_last = rd_word[DATA_W];

  // The arbiter grant lags request by a cycle, so the first idle cycle after
  // request drops may legally still see grant.
  assign req_fell = req_q && !request;

  // Next-cycle occupancy and packet count, used by the FSM lookahead
  always_comb begin
    count_nxt   = count;
    pkt_cnt_nxt = pkt_cnt;
    case ({push, pop_en})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    case ({push && wr_last, pop_en && pop_last})
      2'b10:   pkt_cnt_nxt = pkt_cnt + CW'(1);
      2'b01:   pkt_cnt_nxt = pkt_cnt - CW'(1);
      default: pkt_cnt_nxt = pkt_cnt;
    endcase
    req_nxt = (pkt_cnt_nxt != '0) || (count_nxt == CW'(DEPTH));
  end

  // Word storage write port; contents are don't-care until pointed at
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_last, wr_data};
  end

  // FIFO pointers, occupancy and complete-packet count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pkt_cnt <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      pkt_cnt <= pkt_cnt_nxt;
    end
  end

  // Bus output register: one popped word per granted cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_valid <= 1'b0;
      bus_data  <= '0;
      bus_last  <= 1'b0;
    end else begin
      bus_valid <= pop_en;
      if (pop_en) begin
        bus_data <= rd_word[DATA_W-1:0];
        bus_last <= pop_last;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: tracks idle / waiting / mid-packet
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_nxt) state_nxt = REQ;
      end
      REQ: begin
        if (pop_en) begin
          if (!pop_last)    state_nxt = XFER;
          else if (req_nxt) state_nxt = REQ;
          else              state_nxt = IDLE;
        end else if (!req_nxt) begin
          state_nxt = IDLE;
        end
      end
      XFER: begin
        if (pop_en && pop_last) state_nxt = req_nxt ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Spurious grant detection, exempting the lag cycle after request falls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q          <= 1'b0;
      spurious_grant <= 1'b0;
    end else begin
      req_q          <= request;
      spurious_grant <= grant && (state == IDLE) && !req_fell;
    end
  end

  // Starvation: saturating ungranted-wait counter and sticky flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else begin
      if (starve_clr || grant)
        wait_cnt <= '0;
      else if (request && (wait_cnt != TW'(TIMEOUT)))
        wait_cnt <= wait_cnt + TW'(1);

      if (starve_clr)
        starve <= 1'b0;
      else if (wait_cnt == TW'(TIMEOUT))
        starve <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Testbench for arb_requester: directed stimulus with a word scoreboard.
module tb_arb_requester;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              request;
  logic              grant;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_last;
  logic              starve;
  logic              starve_clr;
  logic              spurious_grant;

  arb_requester #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .request(request), .grant(grant),
    .bus_valid(bus_valid), .bus_data(bus_data), .bus_last(bus_last),
    .starve(starve), .starve_clr(starve_clr), .spurious_grant(spurious_grant)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] mon_e;
  logic auto_grant = 1'b0;
  logic req_h      = 1'b0;
  logic saw_full   = 1'b0;
  int   p0;
  logic [6:0] pat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every bus word must match the next queued expectation
  always @(negedge clk) begin
    if (reset_n && bus_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bus_unexpected: got word %0h last %0b, expected none", bus_data, bus_last);
      end else begin
        mon_e = exp_q.pop_front();
        chk("bus_word", 32'({bus_last, bus_data}), 32'(mon_e));
      end
    end
  end

  // Arbiter model (when enabled): grant is request delayed one cycle
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_grant) grant = req_h;
    req_h = request;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d, input logic l);
    logic done;
    done = 1'b0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = l;
    for (int i = 0; i < 64; i++) begin
      if (wr_ready) begin
        exp_q.push_back({l, d});
        step();
        done = 1'b1;
        break;
      end else begin
        chk("full_request", 32'(request), 32'd1);
        saw_full = 1'b1;
        step();
      end
    end
    chk("push_accepted", 32'(done), 32'd1);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && exp_q.size() != 0; i++) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    auto_grant = 1'b0;
    grant      = 1'b0;
    wr_valid   = 1'b0;
    wr_last    = 1'b0;
    starve_clr = 1'b0;
    req_h      = 1'b0;
    exp_q.delete();
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    reset_n    = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    wr_last    = 1'b0;
    grant      = 1'b0;
    starve_clr = 1'b0;
    #1;
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_request", 32'(request), 32'd0);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_bus_data", 32'(bus_data), 32'd0);
    chk("rst_starve", 32'(starve), 32'd0);
    chk("rst_spurious", 32'(spurious_grant), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Single packet with lagged grant
    auto_grant = 1'b1;
    push_word(8'hA0, 1'b0);
    push_word(8'hA1, 1'b0);
    push_word(8'hA2, 1'b1);
    chk("t1_req_t1", 32'(request), 32'd1);
    chk("t1_bv_t1", 32'(bus_valid), 32'd0);
    step();
    chk("t1_grant_t2", 32'(grant), 32'd1);
    chk("t1_bv_t2", 32'(bus_valid), 32'd0);
    step();
    chk("t1_bv_t3", 32'(bus_valid), 32'd1);
    step();
    chk("t1_bv_t4", 32'(bus_valid), 32'd1);
    step();
    chk("t1_bv_t5", 32'(bus_valid), 32'd1);
    chk("t1_last_t5", 32'(bus_last), 32'd1);
    chk("t1_req_t5", 32'(request), 32'd0);
    step();
    chk("t1_bv_t6", 32'(bus_valid), 32'd0);
    chk("t1_spur_t6", 32'(spurious_grant), 32'd0);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);
    step();
    chk("t1_spur_t7", 32'(spurious_grant), 32'd0);

    // Grant rotating away mid-packet
    do_reset();
    push_word(8'hB0, 1'b0);
    push_word(8'hB1, 1'b0);
    push_word(8'hB2, 1'b0);
    push_word(8'hB3, 1'b1);
    p0  = pulses;
    pat = 7'b1011001;
    for (int i = 0; i < 7; i++) begin
      chk("t2_req_held", 32'(request), 32'd1);
      grant = pat[i];
      step();
      chk("t2_bv_follows_grant", 32'(bus_valid), 32'(pat[i]));
    end
    grant = 1'b0;
    chk("t2_req_drop", 32'(request), 32'd0);
    step();
    chk("t2_pulses", 32'(pulses - p0), 32'd4);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Overlength packet cuts through a full FIFO
    do_reset();
    grant    = 1'b1;
    saw_full = 1'b0;
    for (int k = 0; k < 10; k++) push_word(8'(8'hC0 + k), 1'b0);
    chk("t3_saw_full", 32'(saw_full), 32'd1);
    push_word(8'hCA, 1'b1);
    drain(40);
    step();
    chk("t3_req_idle", 32'(request), 32'd0);
    chk("t3_wr_ready", 32'(wr_ready), 32'd1);
    grant = 1'b0;

    // Starvation and clear
    do_reset();
    push_word(8'hD0, 1'b1);
    for (int i = 0; i < 16; i++) step();
    chk("t4_starve_pre", 32'(starve), 32'd0);
    step();
    chk("t4_starve_set", 32'(starve), 32'd1);
    step();
    chk("t4_starve_sticky", 32'(starve), 32'd1);
    starve_clr = 1'b1;
    step();
    starve_clr = 1'b0;
    chk("t4_starve_clr", 32'(starve), 32'd0);
    step();
    step();
    chk("t4_starve_stays_clr", 32'(starve), 32'd0);
    chk("t4_not_sent", 32'(exp_q.size()), 32'd1);
    grant = 1'b1;
    step();
    grant = 1'b0;
    chk("t4_bv", 32'(bus_valid), 32'd1);
    step();
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // Lag grant exempt, idle grant spurious
    do_reset();
    auto_grant = 1'b1;
    p0 = pulses;
    push_word(8'hE0, 1'b1);
    drain(10);
    chk("t5_spur_lag", 32'(spurious_grant), 32'd0);
    step();
    chk("t5_spur_lag2", 32'(spurious_grant), 32'd0);
    auto_grant = 1'b0;
    grant = 1'b0;
    step();
    step();
    grant = 1'b1;
    step();
    grant = 1'b0;
    chk("t5_spur_pulse", 32'(spurious_grant), 32'd1);
    chk("t5_req_idle", 32'(request), 32'd0);
    chk("t5_wr_ready", 32'(wr_ready), 32'd1);
    step();
    chk("t5_spur_end", 32'(spurious_grant), 32'd0);
    chk("t5_bv_none", 32'(bus_valid), 32'd0);
    chk("t5_pulses", 32'(pulses - p0), 32'd1);

    // Reset mid-transfer, then a clean packet
    do_reset();
    auto_grant = 1'b1;
    p0 = pulses;
    push_word(8'hF0, 1'b0);
    push_word(8'hF1, 1'b0);
    push_word(8'hF2, 1'b0);
    push_word(8'hF3, 1'b0);
    push_word(8'hF4, 1'b1);
    step();
    step();
    step();
    chk("t6_bv_before", 32'(bus_valid), 32'd1);
    @(negedge clk);
    #1;
    auto_grant = 1'b0;
    grant      = 1'b0;
    req_h      = 1'b0;
    reset_n    = 1'b0;
    #1;
    chk("t6_sent_two", 32'(pulses - p0), 32'd2);
    chk("t6_left_three", 32'(exp_q.size()), 32'd3);
    chk("t6_bv", 32'(bus_valid), 32'd0);
    chk("t6_bus_data", 32'(bus_data), 32'd0);
    chk("t6_bus_last", 32'(bus_last), 32'd0);
    chk("t6_request", 32'(request), 32'd0);
    chk("t6_starve", 32'(starve), 32'd0);
    chk("t6_spur", 32'(spurious_grant), 32'd0);
    chk("t6_wr_ready", 32'(wr_ready), 32'd1);
    exp_q.delete();
    step();
    step();
    reset_n = 1'b1;
    step();
    auto_grant = 1'b1;
    p0 = pulses;
    push_word(8'h10, 1'b0);
    push_word(8'h11, 1'b0);
    push_word(8'h12, 1'b1);
    drain(20);
    step();
    chk("t6_new_pulses", 32'(pulses - p0), 32'd3);
    chk("t6_req_idle", 32'(request), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
